// File: rtl/sr_drive_sequencer_pkg.sv
// Shared definitions for the SR flip-flop drive sequencer.
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - cnt_w(): counter width able to hold values 0..maxval
package sr_drive_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SET  = 2'd1;  // S held high
  localparam logic [1:0] ST_RST  = 2'd2;  // R held high
  localparam logic [1:0] ST_GAP  = 2'd3;  // one low cycle between commands

  // Bits needed to hold a count up to and including maxval (min 1 bit).
  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/sr_drive_sequencer_if.sv
// Button/drive bundle of the SR drive sequencer.
//   SetBtn, ResetBtn : raw asynchronous push-button requests (active high)
//   S, R             : registered drives to the SR flip-flop (never both 1)
//   Busy             : pulse or guard cycle in progress
//   Conflict         : one-cycle flag for a set and reset resolved together
//   ExpQ             : expected Q of the driven flip-flop
// master = button/observer side, slave = sequencer side.
interface sr_drive_sequencer_if;
  logic SetBtn;
  logic ResetBtn;
  logic S;
  logic R;
  logic Busy;
  logic Conflict;
  logic ExpQ;

  modport master (output SetBtn, ResetBtn,
                  input  S, R, Busy, Conflict, ExpQ);
  modport slave  (input  SetBtn, ResetBtn,
                  output S, R, Busy, Conflict, ExpQ);
endinterface

// File: rtl/sr_drive_sequencer_sync_debounce.sv
// Two-flop synchroniser + debounce filter + rising-edge detector for one
// push-button.
//   Clk, Rst_n : clock, async active-low reset
//   raw_i      : raw asynchronous button level
//   rise_o     : registered one-cycle pulse on the debounced level's rising edge
module sr_drive_sequencer_sync_debounce
  import sr_drive_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic raw_i,
  output logic rise_o
);

  localparam int             CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count holds how many consecutive samples have disagreed with the
  // debounced level; once it reaches the limit the level flips. The rise
  // pulse is registered on the same edge as the flip so the sequencer can
  // act on it one cycle later.
  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      lvl_d  = ~lvl_q;
      cnt_d  = '0;
      rise_d = ~lvl_q;
    end else if (sync2_q != lvl_q) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sr_drive_sequencer.sv
// SR flip-flop drive sequencer: debounces set/reset buttons and issues clean
// PULSE_W-cycle S or R pulses, each followed by one guard cycle, tracking
// the expected flip-flop state and flagging simultaneous requests.
//   Clk, Rst_n : clock, async active-low reset (aborts any pulse at once)
//   bus        : SetBtn/ResetBtn in; S, R, Busy, Conflict, ExpQ out
// Parameters: DEBOUNCE_CYCLES (1..255), PULSE_W (1..15),
//   RESET_WINS (0: conflicting requests dropped; 1: reset issued).
module sr_drive_sequencer
  import sr_drive_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_W         = 2,
  parameter int RESET_WINS      = 0
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  sr_drive_sequencer_if.slave  bus
);

  localparam int             PW        = cnt_w(PULSE_W);
  localparam logic [PW-1:0]  PCNT_LAST = PW'(PULSE_W - 1);

  logic          set_rise, rst_rise;
  logic          set_req, rst_req;
  logic [1:0]    state_q, state_d;
  logic          set_pend_q, set_pend_d;
  logic          rst_pend_q, rst_pend_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          s_q, s_d, r_q, r_d;
  logic          conf_q, conf_d;
  logic          expq_q, expq_d;

  sr_drive_sequencer_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .raw_i  (bus.SetBtn),
    .rise_o (set_rise)
  );

  sr_drive_sequencer_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .raw_i  (bus.ResetBtn),
    .rise_o (rst_rise)
  );

  // A fresh rise merges with an existing pending flag, so a request landing
  // in the same cycle as IDLE decides is seen immediately and a second
  // request while pending is absorbed.
  assign set_req = set_pend_q | set_rise;
  assign rst_req = rst_pend_q | rst_rise;

  always_comb begin
    state_d    = state_q;
    set_pend_d = set_req;
    rst_pend_d = rst_req;
    pcnt_d     = pcnt_q;
    conf_d     = 1'b0;
    expq_d     = expq_q;
    case (state_q)
      ST_IDLE: begin
        pcnt_d = '0;
        if (set_req && rst_req) begin
          set_pend_d = 1'b0;
          rst_pend_d = 1'b0;
          conf_d     = 1'b1;
          if (RESET_WINS != 0) state_d = ST_RST;
        end else if (set_req) begin
          set_pend_d = 1'b0;
          state_d    = ST_SET;
        end else if (rst_req) begin
          rst_pend_d = 1'b0;
          state_d    = ST_RST;
        end
      end
      ST_SET, ST_RST: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = ST_GAP;
          pcnt_d  = '0;
          expq_d  = (state_q == ST_SET);
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // S and R are decoded from a single next-state value, so they can never
  // be high together.
  assign s_d = (state_d == ST_SET);
  assign r_d = (state_d == ST_RST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      pcnt_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conf_q     <= 1'b0;
      expq_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      pcnt_q     <= pcnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conf_q     <= conf_d;
      expq_q     <= expq_d;
    end
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.Busy     = (state_q != ST_IDLE);
  assign bus.Conflict = conf_q;
  assign bus.ExpQ     = expq_q;

endmodule
